// File: rtl/sha256_round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_round_sequencer_if
// Brief    : Handshake/ROM bundle between the round sequencer and datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_round_sequencer_if #(
  parameter int PASS_W = 2
);
  logic              start;
  logic              abort;
  logic              stall;
  logic [5:0]        round_addr;
  logic [31:0]       kt_in;
  logic [31:0]       kt_out;
  logic [5:0]        round_out;
  logic [PASS_W-1:0] pass_out;
  logic              round_valid;
  logic              first_round;
  logic              last_round;
  logic              busy;
  logic              done;

  // master = sequencer, slave = compression datapath / ROM side
  modport master (
    input  start, abort, stall, kt_in,
    output round_addr, kt_out, round_out, pass_out,
           round_valid, first_round, last_round, busy, done
  );

  modport slave (
    output start, abort, stall, kt_in,
    input  round_addr, kt_out, round_out, pass_out,
           round_valid, first_round, last_round, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/sha256_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sha256_round_sequencer
// Brief    : Steps 64 SHA-256 rounds per pass, aligns K ROM data to rounds.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_round_sequencer #(
  parameter int PASSES = 2,
  parameter int PASS_W = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  sha256_round_sequencer_if.master     bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [PASS_W-1:0] c_LAST_PASS  = PASS_W'(PASSES - 1);
  localparam logic [5:0]        c_LAST_ROUND = 6'd63;

  state_t            r_state;
  logic [5:0]        r_round;
  logic [PASS_W-1:0] r_pass;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic [5:0]        w_round_addr;

  // Under stall the ROM re-reads the current round so Kt stays aligned.
  always_comb begin
    w_round_addr = 6'd0;
    if (r_state == ST_RUN) begin
      w_round_addr = bus.stall ? r_round : (r_round + 6'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_round <= 6'd0;
      r_pass  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state <= ST_IDLE;
        r_round <= 6'd0;
        r_pass  <= '0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              r_state <= ST_PRIME;
              r_busy  <= 1'b1;
            end
          end
          ST_PRIME: begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
          end
          ST_RUN: begin
            if (!bus.stall) begin
              r_round <= r_round + 6'd1;
              if (r_round == c_LAST_ROUND) begin
                if (r_pass == c_LAST_PASS) begin
                  r_state <= ST_DONE;
                  r_pass  <= '0;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  // next pass starts immediately; ROM already fetched K[0]
                  r_pass <= r_pass + 1'b1;
                end
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.round_addr  = w_round_addr;
  assign bus.kt_out      = bus.kt_in;
  assign bus.round_out   = r_round;
  assign bus.pass_out    = r_pass;
  assign bus.round_valid = r_valid;
  assign bus.first_round = r_valid && (r_round == 6'd0);
  assign bus.last_round  = r_valid && (r_round == c_LAST_ROUND);
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_round_sequencer
// Brief    : Scoreboard bench with K ROM model and randomized stall/start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_round_sequencer;

  localparam int P      = 2;
  localparam int PASS_W = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  sha256_round_sequencer_if #(.PASS_W(PASS_W)) bus ();

  sha256_round_sequencer #(.PASSES(P), .PASS_W(PASS_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Registered K ROM: one-cycle read latency.
  initial bus.kt_in = 32'h0;
  always @(posedge clk) bus.kt_in <= K[bus.round_addr];

  typedef struct packed {
    logic [5:0]        r;
    logic [PASS_W-1:0] p;
    logic [31:0]       k;
  } exp_t;

  exp_t q_exp[$];
  int   q_done[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every valid cycle is compared with the head of the queue; a head
  // entry retires only when the datapath accepts it (stall low).
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus.round_valid) begin
        if (q_exp.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = q_exp[0];
          chk("round_out", 32'(bus.round_out), 32'(e.r));
          chk("pass_out", 32'(bus.pass_out), 32'(e.p));
          chk("kt_out", bus.kt_out, e.k);
          chk("first_round", 32'(bus.first_round), 32'(e.r == 6'd0));
          chk("last_round", 32'(bus.last_round), 32'(e.r == 6'd63));
          chk("busy_run", 32'(bus.busy), 32'd1);
          chk("round_addr_run", 32'(bus.round_addr),
              bus.stall ? 32'(e.r) : 32'((int'(e.r) + 1) % 64));
          if (!bus.stall) void'(q_exp.pop_front());
        end
      end else begin
        chk("round_addr_idle", 32'(bus.round_addr), 32'd0);
        chk("first_last_idle", {30'd0, bus.first_round, bus.last_round}, 32'd0);
      end
      if (bus.done) begin
        chk("done_cycle", 32'(cyc), (q_done.size() > 0) ? 32'(q_done[0]) : 32'hffffffff);
        if (q_done.size() > 0) void'(q_done.pop_front());
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 32'(bus.round_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_addr"}, 32'(bus.round_addr), 32'd0);
    chk({tag, "_round"}, 32'(bus.round_out), 32'd0);
    chk({tag, "_pass"}, 32'(bus.pass_out), 32'd0);
  endtask

  // mode: 0 no stall, 1 random stall, 2 stall round 1 x3, 3 stall round 63 pass 0 x2
  task automatic run_job(input int mode, input bit noise, input int abort_at, input int reset_at);
    int  s_cyc, acc, nst, held;
    bit  s, cut;
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.stall = noise ? 1'($urandom % 2) : 1'b0;
    s_cyc = cyc;
    for (int p = 0; p < P; p++) begin
      for (int r = 0; r < 64; r++) begin
        e.r = 6'(r); e.p = PASS_W'(p); e.k = K[r];
        q_exp.push_back(e);
      end
    end
    @(posedge clk); #1;
    bus.start = noise ? 1'($urandom % 2) : 1'b0;
    bus.stall = noise ? 1'($urandom % 2) : 1'b0;
    acc = 0; nst = 0; held = 0; cut = 1'b0;
    while (acc < 64 * P) begin
      @(posedge clk); #1;
      bus.start = noise ? ($urandom % 3 == 0) : 1'b0;
      case (mode)
        1:       s = ($urandom % 4 == 0);
        2:       s = (acc == 1) && (held < 3);
        3:       s = (acc == 63) && (held < 2);
        default: s = 1'b0;
      endcase
      if (acc == abort_at) begin
        bus.abort = 1'b1;
        bus.stall = 1'b0;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        q_exp.delete();
        chk("abort_valid", 32'(bus.round_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        cut = 1'b1;
        break;
      end
      if (acc == reset_at) begin
        bus.stall = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_reset");
        q_exp.delete();
        @(posedge clk); #1;
        bus.start = 1'b0;
        reset_n = 1'b1;
        cut = 1'b1;
        break;
      end
      bus.stall = s;
      if (s) begin
        nst++;
        held++;
      end else begin
        acc++;
      end
    end
    if (!cut) q_done.push_back(s_cyc + 2 + 64 * P + nst);
    @(posedge clk); #1;
    bus.start = cut ? 1'b0 : noise;
    bus.stall = noise ? 1'($urandom % 2) : 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pending", 32'(q_done.size()), 32'd0);
    chk("rounds_pending", 32'(q_exp.size()), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    #1 check_reset_values("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run_job(0, 1'b0, -1, -1);
    run_job(2, 1'b0, -1, -1);
    run_job(3, 1'b0, -1, -1);
    run_job(0, 1'b1, -1, -1);
    for (int i = 0; i < 4; i++) run_job(1, 1'b1, -1, -1);
    run_job(1, 1'b0, 64 + 30, -1);
    run_job(0, 1'b0, -1, -1);
    run_job(1, 1'b0, -1, 40);
    run_job(1, 1'b1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_round_sequencer.md
Name: sha256_round_sequencer

Overview:
- Sequences the 64 SHA-256 compression rounds.
- Drives the round address into the registered K-constant ROM (one-cycle read latency) and re-aligns the returned Kt with its round index.
- Exposes a valid/stall handshake to the compression datapath.
- Supports back-to-back passes for double hashing (e.g. sha256d in the nonce pool) without idle cycles between passes.

Parameters:
PASSES, 2, number of consecutive 64-round passes per start (legal 1..4).
PASS_W, 2, width of pass index output (ceil(log2(PASSES)), minimum 1).

Ports:
clk  input  1  system clock, all state on rising edge.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  begin a job; sampled only in IDLE.
abort  input  1  synchronous cancel; returns to IDLE from any state, no done.
stall  input  1  datapath not consuming this cycle's round; hold current round.
round_addr  output  6  address to K ROM (combinational from state and stall).
kt_in  input  32  ROM data, equal to K[round_addr of previous cycle].
kt_out  output  32  Kt aligned to round_out (passthrough of kt_in).
round_out  output  6  round index being presented.
pass_out  output  PASS_W  current pass index.
round_valid  output  1  round_out/kt_out/pass_out valid this cycle.
first_round  output  1  round_valid and round_out==0.
last_round  output  1  round_valid and round_out==63.
busy  output  1  high in PRIME or RUN.
done  output  1  one-cycle pulse after final round of final pass is accepted.

Behaviour:
- States: IDLE, PRIME, RUN, DONE.
- Reset (async, reset_n=0): state=IDLE, round counter=0, pass=0. Outputs round_valid=0, busy=0, done=0, round_addr=0, round_out=0, pass_out=0.
- IDLE: round_addr=0. start=1 -> PRIME. start is ignored in all other states.
- PRIME (one cycle): round_addr=0 so the ROM loads K[0]; round_valid=0; -> RUN.
- RUN:
  - round_valid=1; round_out=r; kt_out=kt_in=K[r].
  - A round is accepted when round_valid=1 and stall=0.
  - round_addr = stall ? r : (r+1) mod 64. Under stall the ROM re-reads K[r], so Kt stays aligned for any stall length.
  - On acceptance r increments with 6-bit wrap (63 -> 0).
  - On acceptance of r=63: if pass < PASSES-1, pass increments and RUN continues with r=0 next cycle (no bubble; round_addr was 0 in the 63 cycle). If pass == PASSES-1 -> DONE.
- DONE (one cycle): done=1, round_valid=0; -> IDLE. start in the DONE cycle is ignored.
- Latency: start at cycle S gives first round_valid (round 0) at S+2. An unstalled job takes 64*PASSES valid cycles, with done at S+2+64*PASSES.
- abort=1 in any state: next state IDLE, counters cleared, no done pulse. abort beats stall and start in the same cycle.
- Stall outside RUN has no effect.
- reset_n asserted mid-job: immediate return to the reset values; no done pulse.

Test Plan:
- Single job, PASSES=2, stall=0, start at cycle 0: round_valid cycles 2..129. Cycle 2 gives round_out=0, kt_out=428a2f98, first_round=1. Cycle 65 gives round_out=63, kt_out=c67178f2, last_round=1, pass_out=0. Cycle 66 gives round_out=0, pass_out=1, kt_out=428a2f98. done pulses at cycle 130.
- Stall at round 1 for 3 cycles: round_out=1 and kt_out=71374491 held for 4 cycles; round_addr=1 while stalled. Next cycle gives round_out=2, kt_out=b5c0fbcf. done is delayed by exactly 3 cycles.
- Stall asserted during round 63 of pass 0: round_addr=63 and kt_out stays c67178f2. After release, pass_out=1 and round 0 carries kt_out=428a2f98.
- start pulsed while busy and during DONE: no restart, no extra done. A start in IDLE afterwards gives round 0 two cycles later.
- abort at round 30 of pass 1: next cycle state IDLE, round_valid=0, busy=0, no done pulse. A new start gives a fresh pass_out=0, round_out=0.
- reset_n low mid-RUN (async, between edges): outputs go to reset values immediately. Release and start give a normal full job.
